// File: rtl/phys_tag_scoreboard_pkg.sv
// rtl/phys_tag_scoreboard_pkg.sv - shared physical-tag sizing and tag type
package phys_tag_scoreboard_pkg;

  localparam int PREGS     = 30;
  localparam int ARCH_REGS = 6;
  localparam int TAG_W     = 5;
  localparam int WB_PORTS  = 2;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [TAG_W:0]   cnt_t;

  // Tags at or above PREGS are not backed by a physical register.
  function automatic logic tag_in_range(input tag_t t);
    return {1'b0, t} < cnt_t'(PREGS);
  endfunction

endpackage

// File: rtl/tag_free_fifo.sv
// rtl/tag_free_fifo.sv - circular free-tag pool with ascending reset image
module tag_free_fifo
  import phys_tag_scoreboard_pkg::*;
#(
  parameter int FIRST = ARCH_REGS,
  parameter int LAST  = PREGS - 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  tag_t push_tag,
  input  logic pop,
  output tag_t head,
  output cnt_t count
);

  localparam int   DEPTH    = 2 ** TAG_W;
  localparam int   FILL     = LAST - FIRST + 1;
  localparam cnt_t FILL_CNT = cnt_t'(FILL);

  typedef logic [DEPTH-1:0][TAG_W-1:0] image_t;

  function automatic image_t init_image();
    image_t img;
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = (i < FILL) ? tag_t'(FIRST + i) : '0;
    end
    return img;
  endfunction

  localparam image_t IMAGE = init_image();

  image_t mem;
  cnt_t   rd_ptr;
  cnt_t   wr_ptr;
  logic   do_pop;
  logic   do_push;

  assign count  = wr_ptr - rd_ptr;
  assign head   = mem[rd_ptr[TAG_W-1:0]];
  assign do_pop = pop && (count != '0);
  // A push into a full pool is dropped unless a pop frees a slot in the same cycle.
  assign do_push = push && tag_in_range(push_tag) && ((count != FILL_CNT) || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= IMAGE;
      rd_ptr <= '0;
      wr_ptr <= FILL_CNT;
    end else begin
      if (do_push) begin
        mem[wr_ptr[TAG_W-1:0]] <= push_tag;
        wr_ptr                 <= wr_ptr + cnt_t'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + cnt_t'(1);
      end
    end
  end

endmodule

// File: rtl/phys_tag_scoreboard.sv
// rtl/phys_tag_scoreboard.sv - physical tag allocator and done-flag scoreboard
module phys_tag_scoreboard
  import phys_tag_scoreboard_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_valid,
  output logic                      alloc_ready,
  output logic [TAG_W-1:0]          alloc_tag,
  input  logic [WB_PORTS-1:0]       wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0] wb_tag,
  input  logic                      free_valid,
  input  logic [TAG_W-1:0]          free_tag,
  output logic [PREGS-1:0]          done_flags,
  output logic [TAG_W:0]            free_count
);

  logic             alloc_fire;
  logic [PREGS-1:0] done_next;
  tag_t             wt;

  tag_free_fifo #(
    .FIRST(ARCH_REGS),
    .LAST (PREGS - 1)
  ) u_pool (
    .clk     (clk),
    .rst     (rst),
    .push    (free_valid),
    .push_tag(free_tag),
    .pop     (alloc_valid),
    .head    (alloc_tag),
    .count   (free_count)
  );

  assign alloc_ready = (free_count != '0);
  assign alloc_fire  = alloc_valid && alloc_ready;

  // Writebacks set first; the allocation clear is applied last so it wins.
  always_comb begin
    done_next = done_flags;
    wt        = '0;
    for (int i = 0; i < WB_PORTS; i++) begin
      wt = wb_tag[i*TAG_W +: TAG_W];
      if (wb_valid[i] && tag_in_range(wt)) begin
        done_next[wt] = 1'b1;
      end
    end
    if (alloc_fire) begin
      done_next[alloc_tag] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_flags <= '1;
    end else begin
      done_flags <= done_next;
    end
  end

endmodule

// File: tb/tb_phys_tag_scoreboard.sv
// tb/tb_phys_tag_scoreboard.sv - directed bench with queue-based pool model
module tb_phys_tag_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [4:0]  alloc_tag;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_tag;
  logic        free_valid;
  logic [4:0]  free_tag;
  logic [29:0] done_flags;
  logic [5:0]  free_count;

  int checks = 0;
  int errors = 0;

  int          pool[$];
  logic [29:0] mdone;

  phys_tag_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .alloc_valid(alloc_valid),
    .alloc_ready(alloc_ready),
    .alloc_tag  (alloc_tag),
    .wb_valid   (wb_valid),
    .wb_tag     (wb_tag),
    .free_valid (free_valid),
    .free_tag   (free_tag),
    .done_flags (done_flags),
    .free_count (free_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: the pool is a plain queue of tag numbers, done is a bit per tag.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pool.delete();
      for (int t = 6; t < 30; t++) pool.push_back(t);
      mdone = '1;
    end else begin
      int  pre_size;
      int  g;
      bit  granted;
      pre_size = pool.size();
      granted  = alloc_valid && (pre_size > 0);
      if (free_valid && free_tag < 30)
        assert (!(pre_size == 24 && !granted)) else $error("free into full pool");
      for (int i = 0; i < 2; i++) begin
        int wt;
        wt = int'(wb_tag[i*5 +: 5]);
        if (wb_valid[i] && wt < 30) mdone[wt] = 1'b1;
      end
      if (granted) begin
        g = pool.pop_front();
        mdone[g] = 1'b0;
      end
      if (free_valid && free_tag < 30 && (pre_size < 24 || granted))
        pool.push_back(int'(free_tag));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("ready", {31'b0, alloc_ready}, {31'b0, pool.size() != 0});
      chk("count", {26'b0, free_count}, pool.size());
      if (pool.size() != 0) chk("head", {27'b0, alloc_tag}, pool[0]);
      chk("done", {2'b0, done_flags}, {2'b0, mdone});
    end
  end

  task automatic tick(input logic av, input logic fv, input int ft,
                      input logic [1:0] wv, input int w0, input int w1);
    alloc_valid = av;
    free_valid  = fv;
    free_tag    = 5'(ft);
    wb_valid    = wv;
    wb_tag      = {5'(w1), 5'(w0)};
    @(posedge clk);
    #1;
    alloc_valid = 1'b0;
    free_valid  = 1'b0;
    free_tag    = '0;
    wb_valid    = '0;
    wb_tag      = '0;
  endtask

  initial begin
    rst = 1'b0;
    alloc_valid = 1'b0;
    free_valid  = 1'b0;
    free_tag    = '0;
    wb_valid    = '0;
    wb_tag      = '0;
    #12;
    rst = 1'b1;
    chk("rst_count", {26'b0, free_count}, 24);
    chk("rst_tag", {27'b0, alloc_tag}, 6);
    chk("rst_ready", {31'b0, alloc_ready}, 1);
    chk("rst_done", {2'b0, done_flags}, 32'h3FFF_FFFF);

    for (int i = 0; i < 24; i++) begin
      chk("grant_order", {27'b0, alloc_tag}, 6 + i);
      tick(1, 0, 0, 2'b00, 0, 0);
    end
    chk("drain_ready", {31'b0, alloc_ready}, 0);
    chk("drain_count", {26'b0, free_count}, 0);
    chk("drain_done", {2'b0, done_flags}, 32'h0000_003F);

    chk("empty_nogrant", {31'b0, alloc_ready}, 0);
    tick(1, 1, 12, 2'b00, 0, 0);
    chk("refill_ready", {31'b0, alloc_ready}, 1);
    chk("refill_tag", {27'b0, alloc_tag}, 12);
    tick(0, 1, 6, 2'b00, 0, 0);
    tick(1, 0, 0, 2'b00, 0, 0);
    chk("second_tag", {27'b0, alloc_tag}, 6);
    tick(1, 0, 0, 2'b00, 0, 0);
    chk("done6_at_k", {31'b0, done_flags[6]}, 0);
    tick(0, 0, 0, 2'b10, 0, 6);
    chk("done6_k1", {31'b0, done_flags[6]}, 1);

    for (int t = 20; t < 25; t++) tick(0, 1, t, 2'b00, 0, 0);
    chk("cnt5", {26'b0, free_count}, 5);
    chk("cnt5_head", {27'b0, alloc_tag}, 20);
    tick(1, 1, 3, 2'b00, 0, 0);
    chk("swap_count", {26'b0, free_count}, 5);
    chk("swap_head", {27'b0, alloc_tag}, 21);
    for (int i = 0; i < 4; i++) tick(1, 0, 0, 2'b00, 0, 0);
    chk("tail_tag3", {27'b0, alloc_tag}, 3);
    chk("tail_count", {26'b0, free_count}, 1);
    tick(1, 0, 0, 2'b00, 0, 0);

    tick(0, 1, 9, 2'b00, 0, 0);
    chk("head9", {27'b0, alloc_tag}, 9);
    tick(1, 0, 0, 2'b01, 9, 0);
    chk("clear_wins", {31'b0, done_flags[9]}, 0);
    tick(0, 0, 0, 2'b11, 7, 8);
    chk("dual_wb", {30'b0, done_flags[8:7]}, 2'b11);
    tick(0, 1, 30, 2'b01, 31, 0);
    chk("oob_count", {26'b0, free_count}, 0);

    tick(0, 1, 15, 2'b00, 0, 0);
    tick(0, 1, 16, 2'b00, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_count", {26'b0, free_count}, 24);
    chk("mid_rst_tag", {27'b0, alloc_tag}, 6);
    chk("mid_rst_done", {2'b0, done_flags}, 32'h3FFF_FFFF);
    #10;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 2'b00, 0, 0);
    chk("post_rst_tag", {27'b0, alloc_tag}, 9);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phys_tag_scoreboard.md
# phys_tag_scoreboard

Physical-tag allocator and completion scoreboard that sits directly upstream of the sequential issue buffers. It hands out free physical destination tags to dispatch, clears each tag's done flag on allocation, sets it again when an execution unit writes the result back, and returns tags to the free pool on commit. Its registered `done_flags` vector is the `done_flags` input of every issue buffer.

## Interface
- `PREGS`, 30: number of physical tags; width of `done_flags`.
- `ARCH_REGS`, 6: tags `0..ARCH_REGS-1` are mapped to architectural state at reset and are never in the initial free pool.
- `WB_PORTS`, 2: number of writeback ports.
- `TAG_W`, 5: tag width; `2**TAG_W >= PREGS`.

- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `alloc_valid`, in, 1: dispatch requests one tag.
- `alloc_ready`, out, 1: free pool non-empty.
- `alloc_tag`, out, `TAG_W`: tag granted; valid while `alloc_ready`=1.
- `wb_valid`, in, `WB_PORTS`: per-port writeback strobe.
- `wb_tag`, in, `WB_PORTS*TAG_W`: port i tag at `[i*TAG_W +: TAG_W]`.
- `free_valid`, in, 1: commit releases a tag.
- `free_tag`, in, `TAG_W`: tag released.
- `done_flags`, out, `PREGS`: bit t = 1 when tag t's value is available.
- `free_count`, out, `TAG_W+1`: tags currently in the pool.

## Operation
- Free pool: circular FIFO of tags, depth `2**TAG_W`, read/write pointers `TAG_W+1` bits wide. Wrap-around is by pointer overflow. Count is the pointer difference.
- Reset (`rst`=0, asynchronous):
  - FIFO holds `ARCH_REGS..PREGS-1` in ascending order, with read pointer 0 and count `PREGS-ARCH_REGS` (24).
  - `done_flags` is all ones.
  - `alloc_tag` = `ARCH_REGS`, `alloc_ready` = 1, `free_count` = 24.
- Allocate fires on `alloc_valid && alloc_ready`:
  - pops the head;
  - clears `done_flags[alloc_tag]` at the next edge.
- Writeback: each port i with `wb_valid[i]` sets `done_flags[wb_tag_i]` at the next edge. Multiple ports may name distinct tags in the same cycle.
- Free: `free_valid` pushes `free_tag` at the tail. It does not change `done_flags`.
- `alloc_ready` = (count != 0), computed from registered state only. There is no same-cycle bypass from free to alloc. With an empty pool, a simultaneous free makes `alloc_ready`=1 on the following cycle.
- Simultaneous alloc and free: both take effect and the count is unchanged. With count 0 only the free takes effect.
- Same tag allocated and written back in the same cycle: the clear wins, giving bit = 0.
- Writeback to a tag that is not allocated is legal and sets the bit (idempotent).
- Free while the pool is full (count = `PREGS-ARCH_REGS`) is a protocol error. The push is dropped and the count saturates. Verification flags this with an assertion, not a functional check.
- Tags `>= PREGS` on any input are ignored.

## Timing
- `done_flags` is fully registered, so an edge-k writeback is visible in cycle k+1. The issue buffer sees the result one cycle after writeback.
- `alloc_tag` and `alloc_ready` come straight from registered state (FIFO head and count), with no combinational path from any input.
- Throughput is one allocate and one free per cycle, plus `WB_PORTS` writebacks per cycle.
- Asserting reset mid-operation discards everything and restores the reset image immediately.

## Structure
- Shared package holds `PREGS`, `ARCH_REGS`, `TAG_W` and a tag typedef, shared with the issue buffer and rename logic.
- One sub-module: `tag_free_fifo`, the circular FIFO with a parameterised reset image (ascending fill from `ARCH_REGS`), push/pop, and count.
- The top level holds the `done_flags` register with set/clear priority logic.

## Test plan
- Reset, then hold `alloc_valid`=1 for 24 cycles. Required: tags 6..29 granted in order, `done_flags[6..29]` cleared one per cycle, then `alloc_ready`=0 and `free_count`=0.
- Allocate tag 6, then write back 6 on port 1 at cycle k. Required: `done_flags[6]`=0 through cycle k and 1 in cycle k+1.
- Empty pool, then `free_valid` with tag 12 while `alloc_valid`=1. Required: no grant in that cycle; next cycle `alloc_ready`=1 and `alloc_tag`=12.
- Count 5, with alloc and free of tag 3 in the same cycle. Required: count stays 5 and tag 3 is appended behind the existing entries.
- Allocate tag 9 while port 0 writes back 9 in the same cycle. Required: `done_flags[9]`=0. Both ports writing 7 and 8 sets both bits.
- Assert `rst`=0 mid-stream with pointers wrapped. Required: immediate return to count 24, head 6, and all done flags 1.
